// File: rtl/reset_mac_seq.sv
// -----------------------------------------------------------------------------
// reset_mac_seq
//   Staggered reset sequencer for the slow-clocked MAC sub-blocks. After an
//   async reset or a software reset request it holds NUM_CH active-low reset
//   channels for HOLD_TICKS prescaler ticks. It then releases channel 0, and
//   the remaining channels follow in index order, STAGGER_TICKS ticks apart.
//   When STAGGER_TICKS is 0 all channels are released together.
//
// Ports
//   clock      in   system clock; all logic runs on the rising edge
//   reset      in   asynchronous active-low reset
//   prescaler  in   tick enable, one clock wide per slow period
//   soft_reset in   synchronous software reset request, level, active-high
//   sync_reset out  [NUM_CH] per-channel MAC reset, active-low
//   busy       out  high while any channel is still held in reset
//   done       out  one-clock pulse when the last channel is released
// -----------------------------------------------------------------------------
module reset_mac_seq #(
    parameter int NUM_CH        = 3,
    parameter int HOLD_TICKS    = 4,
    parameter int STAGGER_TICKS = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prescaler,
    input  logic              soft_reset,
    output logic [NUM_CH-1:0] sync_reset,
    output logic              busy,
    output logic              done
);

    localparam int MAX_TICKS = (HOLD_TICKS > STAGGER_TICKS) ? HOLD_TICKS : STAGGER_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);
    localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_TICKS - 1);
    // This value is never used when STAGGER_TICKS is 0. It is clamped so the
    // constant stays well formed in that case.
    localparam logic [CNT_W-1:0] STAG_LAST  = CNT_W'((STAGGER_TICKS > 0) ? STAGGER_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] IDX_FIRST  = IDX_W'(1);
    localparam bit               ALL_AT_ONCE = (STAGGER_TICKS == 0) || (NUM_CH == 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r,   cnt_s;
    logic [IDX_W-1:0]    idx_r,   idx_s;
    logic [NUM_CH-1:0]   rel_r,   rel_s;
    logic                busy_r,  busy_s;
    logic                done_r,  done_s;

    // Next-state logic: soft_reset has priority over any prescaler tick.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        rel_s   = rel_r;

        if (soft_reset) begin
            // Restarting here also cancels a release on a coincident tick.
            state_s = ST_HOLD;
            cnt_s   = '0;
            idx_s   = '0;
            rel_s   = '0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (prescaler) begin
                        if (cnt_r == HOLD_LAST) begin
                            cnt_s = '0;
                            if (ALL_AT_ONCE) begin
                                rel_s   = '1;
                                state_s = ST_RUN;
                            end else begin
                                rel_s[0] = 1'b1;
                                idx_s    = IDX_FIRST;
                                state_s  = ST_STAGGER;
                            end
                        end else begin
                            cnt_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_STAGGER: begin
                    if (prescaler) begin
                        if (cnt_r == STAG_LAST) begin
                            cnt_s = '0;
                            // Decoded as a loop so an index past NUM_CH-1
                            // cannot write beyond the vector.
                            for (int k = 0; k < NUM_CH; k++) begin
                                if (idx_r == IDX_W'(k)) begin
                                    rel_s[k] = 1'b1;
                                end else begin
                                    rel_s[k] = rel_r[k];
                                end
                            end
                            if (idx_r == IDX_LAST) begin
                                idx_s   = '0;
                                state_s = ST_RUN;
                            end else begin
                                idx_s = idx_r + IDX_W'(1);
                            end
                        end else begin
                            cnt_s = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_RUN: begin
                    cnt_s = '0;
                    rel_s = '1;
                end
                default: begin
                    state_s = ST_HOLD;
                    cnt_s   = '0;
                    idx_s   = '0;
                    rel_s   = '0;
                end
            endcase
        end

        busy_s = (state_s != ST_RUN);
        done_s = (state_r != ST_RUN) && (state_s == ST_RUN);
    end

    // State, counter, index and release flags, with async reset to the HOLD state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_HOLD;
            cnt_r   <= '0;
            idx_r   <= '0;
            rel_r   <= '0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            rel_r   <= rel_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Gating with reset pulls every channel low immediately, with no clock edge
    // needed.
    assign sync_reset = {NUM_CH{reset}} & rel_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: doc/reset_mac_seq.md
Name: reset_mac_seq

Overview:
- Parametrised MAC reset sequencer; successor of the single-output prescaler-counted reset generator.
- Holds a bank of NUM_CH active-low synchronous resets asserted for HOLD_TICKS prescaler ticks after async reset or software reset request.
- Then releases the channels in order 0..NUM_CH-1, spaced STAGGER_TICKS ticks apart.
- Sits between the reset generator / prescaler and the slow-clocked MAC sub-blocks; reports busy and a one-cycle done pulse to the control register block.

Parameters:
- NUM_CH, 3, number of sync reset channels (1..8).
- HOLD_TICKS, 4, prescaler ticks before channel 0 is released (>=1).
- STAGGER_TICKS, 0, prescaler ticks between consecutive channel releases (0 = all channels released together).

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous active-low reset.
- prescaler  input  1  tick enable, one clock wide per slow period.
- soft_reset  input  1  synchronous software reset request, level, active-high.
- sync_reset  output  NUM_CH  per-channel MAC reset, active-low.
- busy  output  1  high while any channel is still held in reset.
- done  output  1  one-clock pulse when the last channel is released.

Behaviour:
- Internal state: HOLD, STAGGER, RUN. Tick counter width is clog2(max(HOLD_TICKS, STAGGER_TICKS)+1). Channel index width is clog2(NUM_CH) (min 1). Per-channel released flags.
- Async reset low:
  - state=HOLD, counter=0, index=0, all released flags=0, done=0.
  - sync_reset[k] = reset AND released[k], so every channel drops low combinationally with reset, no clock needed.
- HOLD:
  - On each prescaler=1 clock, counter increments.
  - On the tick where counter==HOLD_TICKS-1, release channel 0 and clear counter.
  - If STAGGER_TICKS==0 or NUM_CH==1: release all channels on that same tick and go to RUN.
  - Otherwise go to STAGGER with index=1.
  - Default values release on the 4th tick, matching the legacy generator's 3-edge count.
- STAGGER:
  - Counter counts ticks.
  - On the tick where counter==STAGGER_TICKS-1, release channel[index] and clear counter.
  - If index==NUM_CH-1, go to RUN; else increment index.
- RUN: all channels high; counter idle at 0.
- Timing rules:
  - Releases are registered: sync_reset[k] goes high the clock after the qualifying tick.
  - Channel k release tick number = HOLD_TICKS + k*STAGGER_TICKS.
- busy = (state != RUN), registered, reset value 1.
- done:
  - Registered, high for exactly one clock, coincident with the clock where state first becomes RUN.
  - Reset value 0.
- soft_reset=1 sampled on a clock, from any state including mid-HOLD and mid-STAGGER:
  - Next state HOLD, counter=0, index=0, all released=0, so all sync_reset go low the following clock. busy=1, done=0.
  - While soft_reset stays high, the counter is held at 0 and prescaler ticks are ignored.
  - Counting restarts on the first tick after soft_reset deasserts.
- Priority: async reset > soft_reset > prescaler tick. A soft_reset coincident with a releasing tick cancels that release.
- prescaler held high continuously is legal: every clock counts as a tick.
- No released channel ever re-asserts except via reset or soft_reset.
- Channels never release out of order.
- Counter never exceeds its terminal value (no wrap).

Test Plan:
- Defaults; reset low 3 clocks, then high; prescaler pulse every 5 clocks -> sync_reset=3'b000 until the clock after the 4th tick, then 3'b111; done pulses once; busy falls on that same clock.
- NUM_CH=4, HOLD_TICKS=2, STAGGER_TICKS=3; prescaler every clock -> sync_reset bits rise after ticks 2, 5, 8 and 11 in order 0001, 0011, 0111, 1111; done with the 1111 transition.
- Defaults in RUN; soft_reset high for 1 clock -> sync_reset=000 and busy=1 the next clock; 4 further ticks -> 111 and done pulse again.
- NUM_CH=4, HOLD_TICKS=2, STAGGER_TICKS=3; soft_reset asserted after channel 1 released, held 10 clocks with prescaler toggling -> all 0000 throughout; sequence restarts from tick 0 after deassert.
- Async reset pulled low mid-STAGGER between clock edges -> all sync_reset low immediately (same delta), busy=1, done=0; full sequence repeats after release.
- soft_reset and prescaler high on the same clock as the HOLD terminal tick -> no channel released; counter=0.
